// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module   : instr_fetch_if
// Brief    : Instruction-memory bus, decode handshake and redirect bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redir_jump;
    logic        redir_branch;
    logic [31:0] redir_pc_plus4;
    logic [25:0] redir_index;
    logic [15:0] redir_imm16;

    modport master (
        output imem_req, imem_addr, instr, pc_out, pc_plus4, instr_valid,
        input  imem_rdata, instr_ready, redir_jump, redir_branch,
               redir_pc_plus4, redir_index, redir_imm16
    );

    modport slave (
        input  imem_req, imem_addr, instr, pc_out, pc_plus4, instr_valid,
        output imem_rdata, instr_ready, redir_jump, redir_branch,
               redir_pc_plus4, redir_index, redir_imm16
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : PC, 1-cycle-latency imem reads, 2-entry skid FIFO, redirects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    instr_fetch_if.master bus
);

    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_fly_pc;
    logic [1:0]  r_count;
    logic        r_valid;
    logic [31:0] r_instr0;
    logic [31:0] r_pc0;
    logic [31:0] r_pc4_0;
    logic [31:0] r_instr1;
    logic [31:0] r_pc1;

    logic        w_redir;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_br_tgt;
    logic [31:0] w_target;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;
    logic        w_req;
    logic [31:0] w_addr;
    logic [1:0]  w_count_nxt;

    assign w_jump_tgt = {bus.redir_pc_plus4[31:28], bus.redir_index, 2'b00};
    assign w_br_tgt   = bus.redir_pc_plus4 +
                        {{14{bus.redir_imm16[15]}}, bus.redir_imm16, 2'b00};
    assign w_redir    = bus.redir_jump | bus.redir_branch;
    assign w_target   = bus.redir_jump ? w_jump_tgt : w_br_tgt;

    assign w_pop  = r_valid & bus.instr_ready;
    // The word returning in a redirect cycle belongs to the abandoned path.
    assign w_push = r_inflight & ~w_redir;
    assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_redir) begin
            w_count_nxt = 2'd0;
        end
        if (rst_n) begin
            if (w_redir) begin
                w_req  = 1'b1;
                w_addr = w_target;
            end else begin
                w_req  = (w_occ < 3'd2);
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.instr       = r_instr0;
    assign bus.pc_out      = r_pc0;
    assign bus.pc_plus4    = r_pc4_0;
    assign bus.instr_valid = r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_fly_pc   <= 32'd0;
            r_count    <= 2'd0;
            r_valid    <= 1'b0;
            r_instr0   <= 32'd0;
            r_pc0      <= 32'd0;
            r_pc4_0    <= 32'd4;
            r_instr1   <= 32'd0;
            r_pc1      <= 32'd0;
        end else begin
            r_inflight <= w_req;
            r_fly_pc   <= w_addr;
            if (w_req) begin
                r_pc <= w_addr + 32'd4;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
            // Entry 0 is the head; an empty FIFO keeps its last head visible.
            if (!w_redir) begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_instr0 <= bus.imem_rdata;
                            r_pc0    <= r_fly_pc;
                            r_pc4_0  <= r_fly_pc + 32'd4;
                        end else begin
                            r_instr1 <= bus.imem_rdata;
                            r_pc1    <= r_fly_pc;
                        end
                    end
                    2'b01: begin
                        if (r_count == 2'd2) begin
                            r_instr0 <= r_instr1;
                            r_pc0    <= r_pc1;
                            r_pc4_0  <= r_pc1 + 32'd4;
                        end
                    end
                    2'b11: begin
                        if (r_count == 2'd2) begin
                            r_instr0 <= r_instr1;
                            r_pc0    <= r_pc1;
                            r_pc4_0  <= r_pc1 + 32'd4;
                            r_instr1 <= bus.imem_rdata;
                            r_pc1    <= r_fly_pc;
                        end else begin
                            r_instr0 <= bus.imem_rdata;
                            r_pc0    <= r_fly_pc;
                            r_pc4_0  <= r_fly_pc + 32'd4;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch against a transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_if bus ();
    instr_fetch_if wbus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus.master)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        if (bus.imem_req)  bus.imem_rdata  <= mem_f(bus.imem_addr);
        if (wbus.imem_req) wbus.imem_rdata <= mem_f(wbus.imem_addr);
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_fetch;
    logic [31:0] m_exp;
    int          m_out;
    bit          m_reql;
    int          w_cyc;
    bit          prev_rst = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = 32'h0;
        m_exp   = 32'h0;
        m_out   = 0;
        m_reql  = 1'b0;
        w_cyc   = 0;
    endtask

    // One clock cycle: drive inputs, then check outputs and advance the model.
    task automatic step(input bit rn, input bit rdy, input bit jmp, input bit br,
                        input logic [31:0] p4, input logic [25:0] idx,
                        input logic [15:0] imm);
        logic [31:0] tgt;
        bit ev, pop, er;
        @(negedge clk);
        rst_n              = rn;
        bus.instr_ready    = rdy;
        bus.redir_jump     = jmp;
        bus.redir_branch   = br;
        bus.redir_pc_plus4 = p4;
        bus.redir_index    = idx;
        bus.redir_imm16    = imm;
        #1;
        if (!rn) begin
            chk("req_in_reset", 32'(bus.imem_req), 32'd0);
            chk("wrap_req_in_reset", 32'(wbus.imem_req), 32'd0);
            if (prev_rst) begin
                chk("rst_instr", bus.instr, 32'd0);
                chk("rst_pc_out", bus.pc_out, 32'd0);
                chk("rst_pc_plus4", bus.pc_plus4, 32'd4);
                chk("rst_valid", 32'(bus.instr_valid), 32'd0);
            end
            prev_rst = 1'b1;
            model_reset();
            return;
        end
        prev_rst = 1'b0;

        ev = (m_out - int'(m_reql)) > 0;
        chk("valid", 32'(bus.instr_valid), 32'(ev));
        pop = ev && rdy;
        if (pop) begin
            chk("pc_out", bus.pc_out, m_exp);
            chk("instr", bus.instr, mem_f(m_exp));
            chk("pc_plus4", bus.pc_plus4, m_exp + 32'd4);
            m_exp = m_exp + 32'd4;
        end
        if (jmp || br) begin
            if (jmp) tgt = {p4[31:28], idx, 2'b00};
            else     tgt = p4 + ({{16{imm[15]}}, imm} << 2);
            chk("redir_req", 32'(bus.imem_req), 32'd1);
            chk("redir_addr", bus.imem_addr, tgt);
            m_fetch = tgt + 32'd4;
            m_exp   = tgt;
            m_out   = 1;
            m_reql  = 1'b1;
        end else begin
            er = (m_out - int'(pop)) < 2;
            chk("req", 32'(bus.imem_req), 32'(er));
            if (er) begin
                chk("addr", bus.imem_addr, m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
            m_out  = m_out - int'(pop) + int'(er);
            m_reql = er;
        end

        if (w_cyc < 3) begin
            chk("wrap_addr", wbus.imem_addr, 32'hFFFF_FFF8 + 32'(4 * w_cyc));
        end
        if (w_cyc >= 2 && w_cyc < 5) begin
            chk("wrap_valid", 32'(wbus.instr_valid), 32'd1);
            chk("wrap_pc_out", wbus.pc_out, 32'hFFFF_FFF8 + 32'(4 * (w_cyc - 2)));
        end
        w_cyc++;
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, rdy, 1'b0, 1'b0, 32'd0, 26'd0, 16'd0);
    endtask

    task automatic rand_steps(input int n);
        logic [31:0] r32;
        logic [31:0] p4;
        bit          rdy, redir;
        for (int i = 0; i < n; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            r32   = $urandom;
            p4    = {r32[31:2], 2'b00};
            if (redir)
                step(1'b1, rdy, 1'($urandom_range(0, 1)), 1'b1, p4,
                     26'($urandom), 16'($urandom));
            else
                idle(rdy);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.redir_jump      = 1'b0;
        bus.redir_branch    = 1'b0;
        bus.redir_pc_plus4  = 32'd0;
        bus.redir_index     = 26'd0;
        bus.redir_imm16     = 16'd0;
        wbus.instr_ready    = 1'b1;
        wbus.redir_jump     = 1'b0;
        wbus.redir_branch   = 1'b0;
        wbus.redir_pc_plus4 = 32'd0;
        wbus.redir_index    = 26'd0;
        wbus.redir_imm16    = 16'd0;
        model_reset();

        // Reset, then streaming with decode always ready
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 26'd0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 26'd0, 16'd0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Backpressure then release
        for (int i = 0; i < 5; i++) idle(1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Jump
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0010, 26'h0000040, 16'd0);
        chk("jump_addr_const", bus.imem_addr, 32'h1000_0100);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Branches, backward and forward, from a full FIFO
        idle(1'b0); idle(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 26'd0, 16'hFFFC);
        chk("br_back_const", bus.imem_addr, 32'h0000_0010);
        for (int i = 0; i < 3; i++) idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 26'd0, 16'h0003);
        chk("br_fwd_const", bus.imem_addr, 32'h0000_002C);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Jump and branch together: jump wins
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h2000_0040, 26'h0000100, 16'h0001);
        chk("jump_wins_const", bus.imem_addr, 32'h2000_0400);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Back-to-back redirects
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 26'h0000200, 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 26'd0, 16'h0010);
        for (int i = 0; i < 4; i++) idle(1'b1);

        rand_steps(400);

        // Mid-operation reset with words buffered and in flight
        idle(1'b1); idle(1'b0); idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 16'd0);
        for (int i = 0; i < 10; i++) idle(1'b1);

        rand_steps(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of decode_instr.
- Holds the PC and issues word reads to a synchronous instruction memory with a 1-cycle read latency.
- Buffers returned words in a 2-entry skid FIFO and presents {instr, pc, pc+4} to decode over a valid/ready handshake.
- Applies jump and taken-branch redirects using the imm16 and instr_index fields that decode extracts.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset. Word-aligned.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- imem_req, output, 1, read strobe to instruction memory.
- imem_addr, output, 32, byte address of the read. Bits [1:0] are always 0.
- imem_rdata, input, 32, read data, valid in the cycle after imem_req=1.
- instr, output, 32, instruction word at the FIFO head.
- pc_out, output, 32, address of instr.
- pc_plus4, output, 32, pc_out + 4.
- instr_valid, output, 1, FIFO head is valid.
- instr_ready, input, 1, decode accepts the head. Transfer occurs when instr_valid & instr_ready.
- redir_jump, input, 1, one-cycle pulse: redirect to the jump target.
- redir_branch, input, 1, one-cycle pulse: redirect to the branch target (branch taken).
- redir_pc_plus4, input, 32, pc+4 of the redirecting instruction.
- redir_index, input, 26, instr_index of the jump.
- redir_imm16, input, 16, branch offset in words.

Behaviour:
- **Reset** (rst_n=0 at a clock edge, at any time including mid-operation):
  - pc <= RESET_PC; FIFO count <= 0; inflight <= 0; drop flag <= 0.
  - FIFO entries <= 0, so instr=0, pc_out=0, pc_plus4=4, instr_valid=0.
  - imem_req=0 in every cycle rst_n is low.
- **Start-up:**
  - The first cycle with rst_n high: imem_req=1, imem_addr=RESET_PC.
  - The first instr_valid=1 appears 2 cycles after that request.
- **State:** pc (next fetch address), inflight (a request was issued last cycle), count 0..2, drop flag.
- **Push:** inflight=1 and drop=0 writes imem_rdata with its address and address+4 into the FIFO.
- **Pop:** instr_valid & instr_ready.
- **Issue rule** (every cycle, when not in reset):
  - imem_req = ((count + inflight - pop) < 2).
  - On issue, pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - This sustains 1 instr/cycle when instr_ready is held high.
  - When ready drops, at most 1 word is in flight, and the FIFO absorbs it with no loss.
- **FIFO:**
  - Full (count=2): no issue.
  - Empty: instr_valid=0, and instr/pc_out hold their last values.
  - Simultaneous push and pop at count=1: count stays 1.
  - Ordering is strictly in fetch order.
- **Targets:**
  - Jump target = {redir_pc_plus4[31:28], redir_index, 2'b00}.
  - Branch target = redir_pc_plus4 + sign_ext(redir_imm16) << 2, computed in 32 bits with wrap-around.
  - If redir_jump and redir_branch are both 1, jump wins.
- **Redirect cycle** (either pulse = 1):
  - FIFO count <= 0.
  - imem_rdata arriving this cycle is discarded (no push).
  - The request in this cycle is issued combinationally: imem_req=1, imem_addr=target, pc <= target + 4.
  - Any pop in this cycle is still signalled; decode discards it. No delay slot.
  - The target word reaches instr 2 cycles after the redirect cycle.
  - A redirect while count=2 or while ready=0 behaves identically.
  - Back-to-back redirect pulses: the last one wins.
- **Redirect during reset:** ignored.
- **Registering:** all outputs except imem_req and imem_addr are registered.

Test Plan:
1. Reset release, instr_ready=1, memory returns word = address:
   - imem_addr = 0, 4, 8, … on consecutive cycles.
   - instr_valid rises 2 cycles after the first request.
   - instr/pc_out = 0, 4, 8, … with pc_plus4 = 4, 8, 12.
2. Backpressure:
   - Hold instr_ready=0 for 5 cycles after the first valid: imem_req falls, count saturates at 2, no word is lost.
   - Then release: a gapless sequence 0, 4, 8, 12 continues.
3. Jump:
   - redir_jump=1, redir_pc_plus4=32'h1000_0010, redir_index=26'h0000040: imem_addr=32'h1000_0100 in the same cycle.
   - The next delivered pc_out is 32'h1000_0100. The in-flight word and FIFO contents never appear.
4. Branch:
   - redir_branch=1, redir_pc_plus4=32'h0000_0020, redir_imm16=16'hFFFC: target 32'h0000_0010.
   - With redir_imm16=16'h0003: target 32'h0000_002C.
   - Both redir_jump and redir_branch set: the jump target is taken.
5. Wrap:
   - RESET_PC=32'hFFFF_FFF8: the fetch sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Mid-operation reset:
   - Pull rst_n low for 1 cycle with count=2 and a request in flight: next cycle instr_valid=0, imem_req=0.
   - Fetch restarts at RESET_PC. The stale in-flight word is never delivered.
